load_align_unit: RTL and testbench

- Sequential, parametrised load-alignment stage between the memory interface and register writeback.
- Accepts one load request at a time and issues aligned memory reads: one read, or two when an access crosses a bus word.
- Extracts, sign- or zero-extends, and merges the big-endian data, then returns a registered result over a valid/ready handshake.
- Extends the combinational load shifter with:
  - configurable data width
  - split misaligned accesses
  - true LWL/LWR merging with the old register value
  - backpressure on both sides

---
 rtl/load_align_unit.sv | 155 +++++++++++++++
 tb/tb_load_align_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load-alignment stage: issues one or two aligned bus reads per load request, then
// extracts, extends or merges the big-endian data into a registered writeback result.
module load_align_unit #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TAG_W          = 5,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [1:0]        req_merge,
   input  logic [DATA_W-1:0] req_old,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err
);
   localparam int LANES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(LANES);
   localparam int SPAN_W = OFF_W + 2;

   typedef enum logic [2:0] {IDLE, RD0, WT0, RD1, WT1, OUT} state_t;
   state_t state;

   logic [OFF_W-1:0]  off_p0;
   logic [1:0]        size_p0;
   logic              sgn_p0;
   logic [1:0]        merge_p0;
   logic [DATA_W-1:0] old_p0;
   logic              cross_p0;
   logic [DATA_W-1:0] buf0_p1;

   logic [1:0]        size_n;
   logic [1:0]        merge_n;
   logic [OFF_W-1:0]  off_n;
   logic [SPAN_W-1:0] span_n;
   logic              cross_n;
   logic              accept;

   // {b0,b1} is shifted so lane `off` lands in the MSBs, then shifted back down to
   // right-justify; an arithmetic shift gives the sign extension for free.
   function automatic logic [DATA_W-1:0] align_data(
      input logic [DATA_W-1:0] b0,
      input logic [DATA_W-1:0] b1,
      input logic [DATA_W-1:0] old,
      input logic [OFF_W-1:0]  off,
      input logic [1:0]        size,
      input logic              sgn,
      input logic [1:0]        merge
   );
      logic [OFF_W+2:0]             lsh;
      logic [OFF_W+2:0]             rsh_m;
      logic [7:0]                   rsh;
      logic signed [2*DATA_W-1:0]   cat;
      logic [DATA_W-1:0]            ext;
      logic [DATA_W-1:0]            res;
      lsh   = {off, 3'b000};
      rsh_m = {~off, 3'b000};
      rsh   = 8'(2 * DATA_W) - (8'd8 << size);
      cat   = $signed({b0, b1} << lsh);
      ext   = DATA_W'(sgn ? (cat >>> rsh) : (cat >> rsh));
      case (merge)
         2'd1:    res = (b0 << lsh) | (old & ~({DATA_W{1'b1}} << lsh));
         2'd2:    res = (b0 >> rsh_m) | (old & ~({DATA_W{1'b1}} >> rsh_m));
         default: res = ext;
      endcase
      return res;
   endfunction

   always_comb begin
      size_n = req_size;
      if (DATA_W == 32 && req_size == 2'd3) size_n = 2'd2;
      merge_n = (req_merge == 2'd3) ? 2'd0 : req_merge;
      off_n   = req_addr[OFF_W-1:0];
      span_n  = {2'b00, off_n} + (SPAN_W'(1) << size_n);
      cross_n = (merge_n == 2'd0) && (span_n > SPAN_W'(LANES));
   end

   assign accept        = req_valid && (state == IDLE);
   assign req_ready     = (state == IDLE);
   assign mem_req_valid = (state == RD0) || (state == RD1);
   assign rsp_valid     = (state == OUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         mem_req_addr <= '0;
         rsp_data     <= '0;
         rsp_tag      <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               mem_req_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               rsp_tag      <= req_tag;
               if (cross_n && !MISALIGN_SPLIT) begin
                  rsp_err  <= 1'b1;
                  rsp_data <= '0;
                  state    <= OUT;
               end else begin
                  state <= RD0;
               end
            end
            RD0: if (mem_req_ready) state <= WT0;
            WT0: if (mem_rsp_valid) begin
               if (cross_p0) begin
                  mem_req_addr <= mem_req_addr + ADDR_W'(LANES);
                  state        <= RD1;
               end else begin
                  rsp_data <= align_data(mem_rsp_data, {DATA_W{1'b0}}, old_p0, off_p0,
                                         size_p0, sgn_p0, merge_p0);
                  state    <= OUT;
               end
            end
            RD1: if (mem_req_ready) state <= WT1;
            WT1: if (mem_rsp_valid) begin
               rsp_data <= align_data(buf0_p1, mem_rsp_data, old_p0, off_p0,
                                      size_p0, sgn_p0, merge_p0);
               state    <= OUT;
            end
            OUT: if (rsp_ready) begin
               rsp_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request fields and first beat are only consumed after being loaded, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         off_p0   <= off_n;
         size_p0  <= size_n;
         sgn_p0   <= req_signed;
         merge_p0 <= merge_n;
         old_p0   <= req_old;
         cross_p0 <= cross_n;
      end
      if (state == WT0 && mem_rsp_valid) buf0_p1 <= mem_rsp_data;
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: stimulus queues expected reads and results,
// a memory model and a response monitor pop and compare them independently.
module tb_load_align_unit;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int TAG_W  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [1:0]        req_merge;
   logic [DATA_W-1:0] req_old;
   logic [TAG_W-1:0]  req_tag;
   logic              mem_req_valid, mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_err;

   logic              ns_req_valid, ns_req_ready, ns_mem_req_valid;
   logic [ADDR_W-1:0] ns_mem_req_addr;
   logic              ns_rsp_valid, ns_rsp_err;
   logic [DATA_W-1:0] ns_rsp_data;
   logic [TAG_W-1:0]  ns_rsp_tag;

   always #5 clk = ~clk;

   load_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MISALIGN_SPLIT(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
      .req_signed(req_signed), .req_merge(req_merge), .req_old(req_old), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err)
   );

   load_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MISALIGN_SPLIT(1'b0)) dut_ns (
      .clk(clk), .rst(rst),
      .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_addr(req_addr), .req_size(req_size),
      .req_signed(req_signed), .req_merge(req_merge), .req_old(req_old), .req_tag(req_tag),
      .mem_req_valid(ns_mem_req_valid), .mem_req_ready(1'b1), .mem_req_addr(ns_mem_req_addr),
      .mem_rsp_valid(1'b0), .mem_rsp_data({DATA_W{1'b0}}),
      .rsp_valid(ns_rsp_valid), .rsp_ready(1'b1), .rsp_data(ns_rsp_data), .rsp_tag(ns_rsp_tag),
      .rsp_err(ns_rsp_err)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_rd_q[$];
   int n_tests = 0, n_fail = 0;
   int cyc = 0, last_acc = 0, last_rsp_hs = 0;
   int mem_stall = 0, rsp_stall = 0, rd_hs = 0, rsp_hs = 0;
   bit ns_mreq_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h8899_AABB;
         32'h0000_0104: return 32'h1122_3344;
         default:       return 32'hC0DE_0000 ^ a;
      endcase
   endfunction

   // Memory model: one-cycle response, optional request stalls, read-address scoreboard.
   initial begin
      bit          hs_pend, stalled;
      logic [31:0] hs_addr, stall_addr;
      hs_pend = 1'b0; stalled = 1'b0; hs_addr = '0; stall_addr = '0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_req_ready = 1'b1;
      forever begin
         @(negedge clk);
         mem_rsp_valid = hs_pend;
         mem_rsp_data  = hs_pend ? mem_word(hs_addr) : 32'hDEAD_DEAD;
         if (stalled) begin
            check("mreq_hold_valid", 64'(mem_req_valid), 64'(1));
            check("mreq_hold_addr", 64'(mem_req_addr), 64'(stall_addr));
         end
         if (mem_req_valid && mem_stall > 0) begin
            mem_req_ready = 1'b0;
            mem_stall--;
         end else begin
            mem_req_ready = 1'b1;
         end
         stalled    = mem_req_valid && !mem_req_ready;
         stall_addr = mem_req_addr;
         hs_pend    = mem_req_valid && mem_req_ready;
         if (hs_pend) begin
            hs_addr = mem_req_addr;
            rd_hs++;
            if (exp_rd_q.size() == 0) check("unexpected_read", 64'(mem_req_valid), 64'(0));
            else check("read_addr", 64'(mem_req_addr), 64'(exp_rd_q.pop_front()));
         end
      end
   end

   // Response monitor: pops the expected result on the first valid cycle, then checks holding.
   initial begin
      bit          holding;
      logic [31:0] held_data;
      logic [4:0]  held_tag;
      exp_t        e;
      holding = 1'b0; held_data = '0; held_tag = '0;
      rsp_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (!holding) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 64'(rsp_valid), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data", 64'(rsp_data), 64'(e.data));
                  check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                  check("rsp_err", 64'(rsp_err), 64'(e.err));
                  if (e.lat > 0) check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
               end
            end else begin
               check("hold_data", 64'(rsp_data), 64'(held_data));
               check("hold_tag", 64'(rsp_tag), 64'(held_tag));
            end
            check("req_ready_busy", 64'(req_ready), 64'(0));
            if (rsp_stall > 0) begin
               rsp_ready = 1'b0;
               rsp_stall--;
            end else begin
               rsp_ready = 1'b1;
            end
            holding   = !rsp_ready;
            held_data = rsp_data;
            held_tag  = rsp_tag;
            if (rsp_ready) begin
               last_rsp_hs = cyc + 1;
               rsp_hs++;
            end
         end else begin
            if (holding) check("rsp_dropped", 64'(rsp_valid), 64'(1));
            holding   = 1'b0;
            rsp_ready = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (ns_mem_req_valid) ns_mreq_seen = 1'b1;
   end

   // Called at posedge+2; returns at accept edge+2.
   task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                        input logic [1:0] merge, input logic [31:0] old, input logic [4:0] tag,
                        input logic [31:0] exp_data, input int exp_lat, input int nrd,
                        input bit expect_rsp);
      int w;
      w = 0;
      req_addr = addr; req_size = size; req_signed = sgn; req_merge = merge;
      req_old = old; req_tag = tag; req_valid = 1'b1;
      if (nrd > 0) exp_rd_q.push_back(addr & 32'hFFFF_FFFC);
      if (nrd > 1) exp_rd_q.push_back((addr & 32'hFFFF_FFFC) + 32'd4);
      while (!req_ready && w < 50) begin
         @(posedge clk); #2;
         w++;
      end
      if (!req_ready) begin
         check("accept_timeout", 64'(req_ready), 64'(1));
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #2;
      last_acc  = cyc;
      req_valid = 1'b0;
      if (expect_rsp) exp_q.push_back('{exp_data, tag, 1'b0, exp_lat, last_acc});
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || !req_ready) && w < 100) begin
         @(posedge clk); #2;
         w++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
      check("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_data", 64'(rsp_data), 64'(0));
      check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, w;
      rst = 1'b0; req_valid = 1'b0; ns_req_valid = 1'b0;
      req_addr = '0; req_size = '0; req_signed = 1'b0; req_merge = '0; req_old = '0; req_tag = '0;
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Directed loads, mem word 0x100 = 8899AABB, 0x104 = 11223344.
      issue(32'h101, 2'd0, 1'b1, 2'd0, 32'h0,        5'd1,  32'hFFFF_FF99, 3, 1, 1'b1);
      issue(32'h102, 2'd1, 1'b0, 2'd0, 32'h0,        5'd2,  32'h0000_AABB, 3, 1, 1'b1);
      issue(32'h100, 2'd1, 1'b1, 2'd0, 32'h0,        5'd3,  32'hFFFF_8899, 3, 1, 1'b1);
      issue(32'h103, 2'd2, 1'b0, 2'd0, 32'h0,        5'd4,  32'hBB11_2233, 5, 2, 1'b1);
      issue(32'h101, 2'd2, 1'b0, 2'd1, 32'hDEADBEEF, 5'd5,  32'h99AA_BBEF, 3, 1, 1'b1);
      issue(32'h101, 2'd2, 1'b0, 2'd2, 32'hDEADBEEF, 5'd6,  32'hDEAD_8899, 3, 1, 1'b1);
      issue(32'h103, 2'd2, 1'b0, 2'd2, 32'hDEADBEEF, 5'd7,  32'h8899_AABB, 3, 1, 1'b1);
      issue(32'h100, 2'd2, 1'b0, 2'd2, 32'hDEADBEEF, 5'd8,  32'hDEAD_BE88, 3, 1, 1'b1);
      issue(32'h103, 2'd0, 1'b0, 2'd1, 32'hDEADBEEF, 5'd9,  32'hBBAD_BEEF, 3, 1, 1'b1);
      issue(32'h103, 2'd0, 1'b0, 2'd0, 32'h0,        5'd10, 32'h0000_00BB, 3, 1, 1'b1);
      issue(32'h103, 2'd0, 1'b1, 2'd0, 32'h0,        5'd11, 32'hFFFF_FFBB, 3, 1, 1'b1);
      issue(32'h106, 2'd1, 1'b1, 2'd0, 32'h0,        5'd12, 32'h0000_3344, 3, 1, 1'b1);
      issue(32'h100, 2'd3, 1'b0, 2'd0, 32'h0,        5'd13, 32'h8899_AABB, 3, 1, 1'b1);
      issue(32'h103, 2'd1, 1'b1, 2'd0, 32'h0,        5'd14, 32'hFFFF_BB11, 5, 2, 1'b1);
      issue(32'hFFFF_FFFD, 2'd2, 1'b0, 2'd0, 32'h0,  5'd15, 32'h21FF_FCC0, 5, 2, 1'b1);
      issue(32'h101, 2'd0, 1'b0, 2'd3, 32'hDEADBEEF, 5'd16, 32'h0000_0099, 3, 1, 1'b1);
      wait_idle();

      // Memory-side backpressure.
      mem_stall = 4;
      issue(32'h104, 2'd2, 1'b0, 2'd0, 32'h0, 5'd17, 32'h1122_3344, 0, 1, 1'b1);
      wait_idle();

      // Consumer backpressure; the second request must wait for the first handshake.
      rsp_stall = 3;
      base = rsp_hs;
      issue(32'h100, 2'd0, 1'b1, 2'd0, 32'h0, 5'd18, 32'hFFFF_FF88, 3, 1, 1'b1);
      issue(32'h104, 2'd0, 1'b0, 2'd0, 32'h0, 5'd19, 32'h0000_0011, 3, 1, 1'b1);
      check("accept_after_rsp_hs", 64'(rsp_hs), 64'(base + 1));
      check("accept_cycle_order", 64'(last_acc > last_rsp_hs), 64'(1));
      wait_idle();

      // Asynchronous reset during the second beat of a split load.
      base = rd_hs;
      issue(32'h103, 2'd2, 1'b0, 2'd0, 32'h0, 5'd21, 32'h0, 0, 2, 1'b0);
      w = 0;
      while (rd_hs != base + 2 && w < 20) begin
         @(posedge clk); #2;
         w++;
      end
      check("split_reads_issued", 64'(rd_hs), 64'(base + 2));
      rst = 1'b1;
      #1 check_reset_outputs();
      #4 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         check("no_rsp_after_reset", 64'(rsp_valid), 64'(0));
      end
      issue(32'h100, 2'd2, 1'b1, 2'd0, 32'h0, 5'd22, 32'h8899_AABB, 3, 1, 1'b1);
      wait_idle();

      // Word-crossing load on the non-splitting instance.
      req_addr = 32'h103; req_size = 2'd2; req_signed = 1'b0; req_merge = 2'd0;
      req_old = 32'h0; req_tag = 5'h1D;
      check("ns_req_ready", 64'(ns_req_ready), 64'(1));
      ns_req_valid = 1'b1;
      @(posedge clk); #2;
      ns_req_valid = 1'b0;
      check("ns_rsp_valid", 64'(ns_rsp_valid), 64'(1));
      check("ns_rsp_err", 64'(ns_rsp_err), 64'(1));
      check("ns_rsp_data", 64'(ns_rsp_data), 64'(0));
      check("ns_rsp_tag", 64'(ns_rsp_tag), 64'(5'h1D));
      @(posedge clk); #2;
      check("ns_rsp_done", 64'(ns_rsp_valid), 64'(0));
      check("ns_err_clear", 64'(ns_rsp_err), 64'(0));
      check("ns_back_idle", 64'(ns_req_ready), 64'(1));

      repeat (3) @(posedge clk);
      #2;
      check("ns_no_mem_access", 64'(ns_mreq_seen), 64'(0));
      check("reads_outstanding", 64'(exp_rd_q.size()), 64'(0));
      check("rsp_outstanding", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
